// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types: widths, default reset PC and fetch FSM encoding.
package pipeline_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_ISSUE   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return a & {{(ADDR_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_unit_if import pipeline_pkg::*; ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter flop: async reset to a fixed vector, load-enabled update.
module pc_register
    import pipeline_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem, parks words behind stalls and
// discards the stale response of a fetch that was overtaken by a redirect.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    fetch_unit_if.master       imem,
    output logic [ADDR_W-1:0]  PC_4,
    output logic [INSTR_W-1:0] DO,
    output logic               enableIF,
    output logic               resetIF
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               pc_load;
    logic [ADDR_W-1:0]  hold_pc4;
    logic [INSTR_W-1:0] hold_instr;
    logic               hold_load;
    logic [ADDR_W-1:0]  stale_addr;
    logic               stale_load;
    logic               ack;

    pc_register #(
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .reloj (reloj),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_nxt),
        .q     (pc)
    );

    assign pc_plus4 = pc + 32'd4;
    assign ack      = imem.imem_ack;
    assign resetIF  = reset | redirect;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_plus4;
        pc_load        = 1'b0;
        hold_load      = 1'b0;
        stale_load     = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        PC_4           = pc_plus4;
        DO             = imem.imem_data;
        enableIF       = 1'b0;

        case (state)
            ST_ISSUE: begin
                imem.imem_req = 1'b1;
                if (redirect) begin
                    pc_nxt  = word_align(redirect_pc);
                    pc_load = 1'b1;
                    if (!ack) begin
                        stale_load = 1'b1;
                        state_nxt  = ST_DISCARD;
                    end
                end else if (ack) begin
                    pc_load = 1'b1;
                    if (stall) begin
                        hold_load = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        enableIF = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                PC_4 = hold_pc4;
                DO   = hold_instr;
                if (redirect) begin
                    pc_nxt    = word_align(redirect_pc);
                    pc_load   = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (!stall) begin
                    enableIF  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_DISCARD: begin
                // Keep presenting the overtaken address until memory answers.
                imem.imem_req  = 1'b1;
                imem.imem_addr = stale_addr;
                if (redirect) begin
                    pc_nxt  = word_align(redirect_pc);
                    pc_load = 1'b1;
                end else if (ack) begin
                    state_nxt = ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase

        if (reset) begin
            imem.imem_req = 1'b0;
            enableIF      = 1'b0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state      <= ST_ISSUE;
            hold_pc4   <= '0;
            hold_instr <= '0;
            stale_addr <= '0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_pc4   <= pc_plus4;
                hold_instr <= imem.imem_data;
            end
            if (stale_load) begin
                stale_addr <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit plus directed corner cases.
module tb_fetch_unit;
    import pipeline_pkg::*;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        reloj = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ack_en;
    logic [31:0] PC_4;
    logic [31:0] DO;
    logic        enableIF;
    logic        resetIF;
    logic [31:0] w_pc4;
    logic [31:0] w_do;
    logic        w_en;
    logic        w_rif;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] next_gen;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 reloj = ~reloj;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    fetch_unit_if m_if();
    fetch_unit_if w_if();

    assign m_if.imem_ack  = ack_en;
    assign m_if.imem_data = mem_word(m_if.imem_addr);
    assign w_if.imem_ack  = 1'b1;
    assign w_if.imem_data = mem_word(w_if.imem_addr);

    fetch_unit u_dut (
        .reloj       (reloj),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (m_if.master),
        .PC_4        (PC_4),
        .DO          (DO),
        .enableIF    (enableIF),
        .resetIF     (resetIF)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_wrap (
        .reloj       (reloj),
        .reset       (reset),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .imem        (w_if.master),
        .PC_4        (w_pc4),
        .DO          (w_do),
        .enableIF    (w_en),
        .resetIF     (w_rif)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    // Expected stream: consecutive words from the last redirect/reset target.
    task automatic topup();
        while (sb.size() < 4) begin
            sb.push_back('{pc4: next_gen + 32'd4, instr: mem_word(next_gen)});
            next_gen = next_gen + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        sb.delete();
        next_gen = a & 32'hFFFF_FFFC;
        topup();
    endtask

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    always @(negedge reloj) begin
        exp_t e;
        check("resetIF", 32'(resetIF), 32'(reset | redirect));
        check("en_and_rst", 32'(enableIF & resetIF), 32'd0);
        if (prev_wait && !reset) begin
            check("addr_stable", m_if.imem_addr, prev_addr);
            check("req_stable", 32'(m_if.imem_req), 32'd1);
        end
        prev_wait = !reset && m_if.imem_req && !m_if.imem_ack;
        prev_addr = m_if.imem_addr;
        if (enableIF) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: got delivery %h expected none",
                         PC_4);
            end else begin
                e = sb.pop_front();
                check("deliv_pc4", PC_4, e.pc4);
                check("deliv_instr", DO, e.instr);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ack_en      = 1'b0;
        restart(DEFAULT_RESET_PC);

        repeat (2) @(posedge reloj);
        @(negedge reloj);
        check("rst_req", 32'(m_if.imem_req), 32'd0);
        check("rst_en", 32'(enableIF), 32'd0);
        check("rst_rif", 32'(resetIF), 32'd1);
        check("rst_addr", m_if.imem_addr, 32'h0);
        check("rst_waddr", w_if.imem_addr, 32'hFFFF_FFFC);

        step();
        reset  = 1'b0;
        ack_en = 1'b1;
        @(negedge reloj);
        check("first_addr", m_if.imem_addr, 32'h0);
        check("first_req", 32'(m_if.imem_req), 32'd1);
        check("first_en", 32'(enableIF), 32'd1);
        check("wrap_addr0", w_if.imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc4_0", w_pc4, 32'h0);
        check("wrap_en", 32'(w_en), 32'd1);
        step();
        topup();
        @(negedge reloj);
        check("wrap_addr1", w_if.imem_addr, 32'h0);
        check("wrap_pc4_1", w_pc4, 32'h4);
        check("seq_addr1", m_if.imem_addr, 32'h4);
        check("seq_pc4_1", PC_4, 32'h8);
        step();
        topup();
        @(negedge reloj);
        check("seq_addr2", m_if.imem_addr, 32'h8);
        check("seq_pc4_2", PC_4, 32'hC);

        repeat (800) begin
            step();
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 10) == 0;
            redirect_pc = $urandom;
            ack_en      = ($urandom % 3) != 0;
            if (redirect) restart(redirect_pc);
            topup();
        end

        repeat (3) begin
            step();
            stall    = 1'b0;
            redirect = 1'b0;
            ack_en   = 1'b1;
            topup();
        end

        // Stall while a word at 0x10 is acknowledged.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        restart(32'h10);
        step();
        redirect = 1'b0;
        stall    = 1'b1;
        topup();
        @(negedge reloj);
        check("st_addr", m_if.imem_addr, 32'h10);
        check("st_en0", 32'(enableIF), 32'd0);
        repeat (2) begin
            step();
            topup();
            @(negedge reloj);
            check("hold_req", 32'(m_if.imem_req), 32'd0);
            check("hold_pc4", PC_4, 32'h14);
            check("hold_do", DO, mem_word(32'h10));
            check("hold_en", 32'(enableIF), 32'd0);
        end
        step();
        stall = 1'b0;
        @(negedge reloj);
        check("unhold_en", 32'(enableIF), 32'd1);
        check("unhold_pc4", PC_4, 32'h14);
        step();
        topup();
        @(negedge reloj);
        check("after_hold_addr", m_if.imem_addr, 32'h14);
        check("after_hold_req", 32'(m_if.imem_req), 32'd1);

        // Redirect and stall together while holding.
        step();
        stall = 1'b1;
        topup();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h2000;
        restart(32'h2000);
        @(negedge reloj);
        check("hr_rif", 32'(resetIF), 32'd1);
        check("hr_en", 32'(enableIF), 32'd0);

        // Redirect in the first wait cycle of a slow fetch.
        step();
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        ack_en      = 1'b0;
        restart(32'h100);
        @(negedge reloj);
        check("hr_next_addr", m_if.imem_addr, 32'h2000);
        check("hr_next_req", 32'(m_if.imem_req), 32'd1);
        step();
        redirect = 1'b0;
        topup();
        @(negedge reloj);
        check("disc_addr", m_if.imem_addr, 32'h2000);
        check("disc_en", 32'(enableIF), 32'd0);
        step();
        ack_en = 1'b1;
        @(negedge reloj);
        check("disc_ack_en", 32'(enableIF), 32'd0);
        check("disc_ack_addr", m_if.imem_addr, 32'h2000);
        step();
        ack_en = 1'b0;
        @(negedge reloj);
        check("post_disc_addr", m_if.imem_addr, 32'h100);
        check("post_disc_req", 32'(m_if.imem_req), 32'd1);

        // Reset while discarding, with an ack in the same cycle.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        restart(32'h40);
        step();
        redirect = 1'b0;
        ack_en   = 1'b1;
        #1;
        reset = 1'b1;
        restart(DEFAULT_RESET_PC);
        #1;
        check("ar_req", 32'(m_if.imem_req), 32'd0);
        check("ar_en", 32'(enableIF), 32'd0);
        check("ar_rif", 32'(resetIF), 32'd1);
        check("ar_addr", m_if.imem_addr, 32'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rel_addr", m_if.imem_addr, 32'h0);
        check("rel_req", 32'(m_if.imem_req), 32'd1);

        repeat (300) begin
            step();
            stall       = ($urandom % 3) == 0;
            redirect    = ($urandom % 12) == 0;
            redirect_pc = $urandom;
            ack_en      = ($urandom % 2) != 0;
            if (redirect) restart(redirect_pc);
            topup();
        end

        step();
        @(negedge reloj);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
